flag_branch_unit: RTL and testbench

//  Consumes the {S,Z,C,V} flags produced by the ALU's FLAG_OUT. Holds them in a

---
 rtl/flag_branch_unit.sv | 109 ++++++++++
 tb/tb_flag_branch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// Condition-code register, branch resolver and program counter.
// Taken branches redirect the PC and hold fetch in flush for FLUSH_CYCLES.
module flag_branch_unit #(
  parameter int unsigned PC_WIDTH     = 16,
  parameter int unsigned PC_STEP      = 1,
  parameter int unsigned RESET_PC     = 0,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          flag_in,
  input  logic                flag_we,
  input  logic                pc_en,
  input  logic                br_valid,
  input  logic [3:0]          br_cond,
  input  logic [PC_WIDTH-1:0] br_target,
  output logic                br_ready,
  output logic                br_done,
  output logic                br_taken,
  output logic                flush,
  output logic [PC_WIDTH-1:0] pc,
  output logic [3:0]          flag_q
);

  localparam int unsigned CW =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic [3:0] f;
  logic       s, z, c, v, lt;
  logic       cond_ok;
  logic       accept;

  // Flags written this cycle are forwarded into the condition check
  always_comb begin
    f            = flag_we ? flag_in : flag_q;
    {s, z, c, v} = f;
    lt           = s ^ v;
    cond_ok      = 1'b0;
    unique case (br_cond)
      4'h0: cond_ok = 1'b1;
      4'h1: cond_ok = z;
      4'h2: cond_ok = !z;
      4'h3: cond_ok = lt;
      4'h4: cond_ok = !lt;
      4'h5: cond_ok = z | lt;
      4'h6: cond_ok = !z & !lt;
      4'h7: cond_ok = c;
      4'h8: cond_ok = !c;
      4'h9: cond_ok = s;
      4'hA: cond_ok = !s;
      4'hB: cond_ok = v;
      4'hC: cond_ok = !v;
      4'hD, 4'hE, 4'hF: cond_ok = 1'b0;
    endcase
  end

  assign accept = br_valid & br_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pc       <= PC_WIDTH'(RESET_PC);
      flag_q   <= 4'b0;
      br_done  <= 1'b0;
      br_taken <= 1'b0;
      flush    <= 1'b0;
      br_ready <= 1'b1;
    end else begin
      if (flag_we)
        flag_q <= flag_in;
      br_done  <= accept;
      br_taken <= accept & cond_ok;
      unique case (state)
        S_IDLE: begin
          if (accept && cond_ok) begin
            pc <= br_target;
            if (FLUSH_CYCLES > 0) begin
              state    <= S_FLUSH;
              cnt      <= CW'(FLUSH_CYCLES);
              flush    <= 1'b1;
              br_ready <= 1'b0;
            end
          end else if (pc_en) begin
            pc <= pc + PC_WIDTH'(PC_STEP);
          end
        end
        S_FLUSH: begin
          if (cnt == CW'(1)) begin
            state    <= S_IDLE;
            flush    <= 1'b0;
            br_ready <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: cycle model for PC/flags/flush
// plus a scoreboard of expected branch outcomes.
module tb_flag_branch_unit;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  flag_in;
  logic        flag_we;
  logic        pc_en;
  logic        br_valid;
  logic [3:0]  br_cond;
  logic [15:0] br_target;
  logic        br_ready;
  logic        br_done;
  logic        br_taken;
  logic        flush;
  logic [15:0] pc;
  logic [3:0]  flag_q;

  flag_branch_unit #(
    .PC_WIDTH(16),
    .PC_STEP(1),
    .RESET_PC(0),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flag_in(flag_in),
    .flag_we(flag_we),
    .pc_en(pc_en),
    .br_valid(br_valid),
    .br_cond(br_cond),
    .br_target(br_target),
    .br_ready(br_ready),
    .br_done(br_done),
    .br_taken(br_taken),
    .flush(flush),
    .pc(pc),
    .flag_q(flag_q)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic [15:0] m_pc;
  logic [3:0]  m_flag;
  int          m_cnt;
  bit          exp_tk;
  bit          sb_q[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    bit acc;
    acc = br_valid && (m_cnt == 0);
    if (acc)
      sb_q.push_back(exp_tk);
    @(posedge clk);
    #1;
    if (flag_we)
      m_flag = flag_in;
    if (acc && exp_tk) begin
      m_pc  = br_target;
      m_cnt = FC;
    end else if (m_cnt > 0) begin
      m_cnt--;
    end else if (pc_en) begin
      m_pc = m_pc + 16'd1;
    end
    check("pc", pc, m_pc);
    check("flag_q", flag_q, m_flag);
    check("flush", flush, m_cnt > 0);
    check("br_ready", br_ready, m_cnt == 0);
    check("br_done", br_done, acc);
    if (br_done) begin
      if (sb_q.size() == 0)
        check("sb_underflow", sb_q.size(), 1);
      else
        check("br_taken", br_taken, sb_q.pop_front());
    end else begin
      check("br_taken_idle", br_taken, 0);
    end
  endtask

  task automatic do_br(input logic [3:0] cond, input logic [15:0] tgt,
                       input bit tk);
    br_valid  = 1'b1;
    br_cond   = cond;
    br_target = tgt;
    exp_tk    = tk;
    step();
    br_valid = 1'b0;
    while (m_cnt > 0)
      step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_pc", pc, 16'h0000);
    check("rst_flag_q", flag_q, 4'h0);
    check("rst_flush", flush, 0);
    check("rst_br_done", br_done, 0);
    check("rst_br_taken", br_taken, 0);
    m_pc   = 16'h0000;
    m_flag = 4'h0;
    m_cnt  = 0;
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_br_ready", br_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    flag_in   = 4'h0;
    flag_we   = 1'b0;
    pc_en     = 1'b0;
    br_valid  = 1'b0;
    br_cond   = 4'h0;
    br_target = 16'h0;
    exp_tk    = 1'b0;
    m_cnt     = 0;
    do_reset();

    // EQ after Z flag write, target 0x0040
    pc_en   = 1'b1;
    flag_we = 1'b1;
    flag_in = 4'b0100;
    step();
    flag_we = 1'b0;
    step();
    do_br(4'h1, 16'h0040, 1'b1);
    step();
    check("pc_resume", pc, 16'h0041);

    // forwarding: flag register cleared, new flags same cycle
    flag_we = 1'b1;
    flag_in = 4'b0000;
    step();
    flag_in = 4'b1001;
    do_br(4'h3, 16'h0200, 1'b0);
    flag_in = 4'b0000;
    step();
    flag_in = 4'b1001;
    do_br(4'h4, 16'h0200, 1'b1);
    flag_we = 1'b0;

    // flags from 3-5
    flag_we = 1'b1;
    flag_in = 4'b1010;
    step();
    flag_we = 1'b0;
    do_br(4'h7, 16'h0300, 1'b1);
    do_br(4'h3, 16'h0310, 1'b1);
    do_br(4'h8, 16'h0320, 1'b0);
    do_br(4'h2, 16'h0330, 1'b1);
    do_br(4'h9, 16'h0340, 1'b1);
    do_br(4'h6, 16'h0350, 1'b0);

    // zero result flags
    flag_we = 1'b1;
    flag_in = 4'b0100;
    step();
    flag_we = 1'b0;
    do_br(4'h5, 16'h0400, 1'b1);
    do_br(4'h6, 16'h0410, 1'b0);
    do_br(4'hA, 16'h0420, 1'b1);
    do_br(4'hB, 16'h0430, 1'b0);
    do_br(4'hC, 16'h0440, 1'b1);
    do_br(4'hE, 16'h0450, 1'b0);
    do_br(4'hF, 16'h0460, 1'b0);

    // wrap and reserved condition
    do_br(4'h0, 16'hFFFE, 1'b1);
    step();
    check("pc_ffff", pc, 16'hFFFF);
    step();
    check("pc_wrap", pc, 16'h0000);
    do_br(4'hD, 16'h1234, 1'b0);

    // request held through flush is accepted once on first idle cycle
    br_valid  = 1'b1;
    br_cond   = 4'h0;
    br_target = 16'h0080;
    exp_tk    = 1'b1;
    step();
    br_cond   = 4'hF;
    br_target = 16'h0090;
    exp_tk    = 1'b0;
    for (int i = 0; i < FC + 1; i++)
      step();
    br_valid = 1'b0;
    step();
    step();

    // random flag writes and PC stepping
    for (int i = 0; i < 40; i++) begin
      flag_we = 1'($urandom_range(0, 1));
      flag_in = 4'($urandom_range(0, 15));
      pc_en   = 1'($urandom_range(0, 1));
      step();
    end
    flag_we = 1'b0;
    pc_en   = 1'b1;

    // asynchronous reset in the middle of a flush
    br_valid  = 1'b1;
    br_cond   = 4'h0;
    br_target = 16'h0777;
    exp_tk    = 1'b1;
    step();
    br_valid = 1'b0;
    check("mid_flush", flush, 1);
    do_reset();
    step();
    step();

    check("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
